// File: rtl/game_ctrl.sv
// game_ctrl: frame-rate game sequencer (TITLE -> PLAY -> DYING -> OVER).
//
// Ports:
//   clk_pix    in   pixel clock, only clock
//   rst_pix    in   asynchronous active-high reset
//   frame      in   one-cycle pulse at start of frame
//   hit        in   frog/hazard collision, any cycle, any duration
//   btn_start  in   start button level, synchronous to clk_pix
//   state      out  [1:0] 0 TITLE, 1 PLAY, 2 DYING, 3 OVER (FSM debug view)
//   run        out  high only in PLAY (gates sprite motion)
//   dying      out  high only in DYING
//   respawn    out  one-cycle pulse requesting sprite position re-init
//   lives      out  [1:0] remaining lives
//   score      out  [15:0] 4-digit BCD score, [15:12] most significant
//   hiscore    out  [15:0] 4-digit BCD best completed-game score
//
// Handshakes: there is no valid/ready traffic here; frame and the start
// edge are single-cycle qualifiers sampled on the clk_pix rising edge, and
// every output is a register updated on that same edge.
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SCORE_FRAMES = 60,
  parameter int DIE_FRAMES   = 120,
  parameter int OVER_FRAMES  = 180
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic        frame,
  input  logic        hit,
  input  logic        btn_start,
  output logic [1:0]  state,
  output logic        run,
  output logic        dying,
  output logic        respawn,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic [15:0] hiscore
);

  localparam logic [1:0] ST_TITLE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DYING = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  // One shared frame timer, sized for the longest phase.
  localparam int MAXP_SD = (SCORE_FRAMES > DIE_FRAMES) ? SCORE_FRAMES : DIE_FRAMES;
  localparam int MAXP    = (MAXP_SD > OVER_FRAMES) ? MAXP_SD : OVER_FRAMES;
  localparam int TW      = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [TW-1:0] SCORE_LAST = TW'(SCORE_FRAMES - 1);
  localparam logic [TW-1:0] DIE_LAST   = TW'(DIE_FRAMES - 1);
  localparam logic [TW-1:0] OVER_LAST  = TW'(OVER_FRAMES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
  localparam logic [15:0]   SCORE_MAX  = 16'h9999;

  logic          btn_q;
  logic          hit_lat;
  logic [TW-1:0] ftimer;
  logic          start_pe;
  logic          hit_eff;

  assign start_pe = btn_start & ~btn_q;
  // A hit seen earlier in the frame, or on the frame cycle itself, counts.
  assign hit_eff  = hit_lat | hit;

  // Ripple BCD increment; a 9 digit wraps to 0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state   <= ST_TITLE;
      run     <= 1'b0;
      dying   <= 1'b0;
      respawn <= 1'b0;
      lives   <= 2'd0;
      score   <= 16'h0000;
      hiscore <= 16'h0000;
      btn_q   <= 1'b0;
      hit_lat <= 1'b0;
      ftimer  <= '0;
    end else begin
      btn_q   <= btn_start;
      respawn <= 1'b0;

      // The latch only arms during PLAY; every frame consumes it.
      if (frame) begin
        hit_lat <= 1'b0;
      end else if (state == ST_PLAY && hit) begin
        hit_lat <= 1'b1;
      end

      case (state)
        ST_TITLE: begin
          if (start_pe) begin
            state   <= ST_PLAY;
            run     <= 1'b1;
            dying   <= 1'b0;
            lives   <= LIVES_INIT;
            score   <= 16'h0000;
            respawn <= 1'b1;
            ftimer  <= '0;
          end
        end

        ST_PLAY: begin
          if (frame) begin
            if (hit_eff) begin
              state  <= ST_DYING;
              run    <= 1'b0;
              dying  <= 1'b1;
              ftimer <= '0;
            end else if (ftimer == SCORE_LAST) begin
              ftimer <= '0;
              if (score != SCORE_MAX) begin
                score <= bcd_inc(score);
              end
            end else begin
              ftimer <= ftimer + 1'b1;
            end
          end
        end

        ST_DYING: begin
          if (frame) begin
            if (ftimer == DIE_LAST) begin
              ftimer <= '0;
              dying  <= 1'b0;
              if (lives == 2'd1) begin
                state <= ST_OVER;
                run   <= 1'b0;
                lives <= 2'd0;
                // Packed BCD digits order the same as binary.
                if (score > hiscore) begin
                  hiscore <= score;
                end
              end else begin
                state   <= ST_PLAY;
                run     <= 1'b1;
                lives   <= lives - 2'd1;
                respawn <= 1'b1;
              end
            end else begin
              ftimer <= ftimer + 1'b1;
            end
          end
        end

        default: begin // ST_OVER
          if (start_pe && ftimer == OVER_LAST) begin
            state   <= ST_PLAY;
            run     <= 1'b1;
            dying   <= 1'b0;
            lives   <= LIVES_INIT;
            score   <= 16'h0000;
            respawn <= 1'b1;
            ftimer  <= '0;
          end else if (frame && ftimer != OVER_LAST) begin
            ftimer <= ftimer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
